// File: rtl/cpu_cmd_sequencer.sv
// Host-side command issuer: buffers host commands in a small FIFO, paces each one
// through the CPU's cpu_rdy handshake and returns a tagged zero/error/timeout result.
module cpu_cmd_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [6:0]               host_cmd,
  input  logic [WIDTH-1:0]         host_d1,
  input  logic [WIDTH-1:0]         host_d2,
  input  logic [WIDTH-1:0]         host_d3,
  output logic [6:0]               cmd_in,
  output logic [WIDTH-1:0]         din_1,
  output logic [WIDTH-1:0]         din_2,
  output logic [WIDTH-1:0]         din_3,
  input  logic                     cpu_rdy,
  input  logic                     zero,
  input  logic                     error,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_tag,
  output logic                     res_zero,
  output logic                     res_error,
  output logic                     res_timeout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam int EW = 7 + 3 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       count_q, count_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [6:0]        cmd_q, cmd_d;
  logic [WIDTH-1:0]  d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic              rv_q, rv_d, rz_q, rz_d, re_q, re_d, rt_q, rt_d;
  logic [7:0]        rtag_q, rtag_d, tag_q, tag_d;
  logic              busy_q, busy_d;
  logic              push, pop, full, empty;
  logic [EW-1:0]     head;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign host_ready = !full;
  assign push       = host_valid && host_ready;
  // The result slot must be free, or freed this very cycle, before issuing.
  assign pop        = (state_q == IDLE) && !empty && cpu_rdy && (!rv_q || res_ready);
  assign head       = mem_q[rd_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    rv_d    = rv_q && !res_ready;
    rz_d    = rz_q;
    re_d    = re_q;
    rt_d    = rt_q;
    rtag_d  = rtag_q;
    tag_d   = tag_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          {cmd_d, d1_d, d2_d, d3_d} = head;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!cpu_rdy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          rv_d = 1'b1; rz_d = 1'b0; re_d = 1'b0; rt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (cpu_rdy) begin
          state_d = IDLE;
          rv_d = 1'b1; rz_d = zero; re_d = error; rt_d = 1'b0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          rv_d = 1'b1; rz_d = 1'b0; re_d = 1'b0; rt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Any return to IDLE retires the command: NOP on the bus, tag posted and advanced.
    if (state_q != IDLE && state_d == IDLE) begin
      cmd_d  = 7'b0000000;
      rtag_d = tag_q;
      tag_d  = tag_q + 8'd1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {host_cmd, host_d1, host_d2, host_d3};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      cmd_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      rv_q    <= 1'b0;
      rz_q    <= 1'b0;
      re_q    <= 1'b0;
      rt_q    <= 1'b0;
      rtag_q  <= '0;
      tag_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_d;
      cmd_q   <= cmd_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      rv_q    <= rv_d;
      rz_q    <= rz_d;
      re_q    <= re_d;
      rt_q    <= rt_d;
      rtag_q  <= rtag_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd_in      = cmd_q;
  assign din_1       = d1_q;
  assign din_2       = d2_q;
  assign din_3       = d3_q;
  assign res_valid   = rv_q;
  assign res_zero    = rz_q;
  assign res_error   = re_q;
  assign res_timeout = rt_q;
  assign res_tag     = rtag_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Directed bench for cpu_cmd_sequencer: issue, fill, timeout, backpressure,
// error capture with tag wrap, and asynchronous reset mid-command.
module tb_cpu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [6:0] host_cmd = '0;
  logic [7:0] host_d1 = '0, host_d2 = '0, host_d3 = '0;
  logic [6:0] cmd_in;
  logic [7:0] din_1, din_2, din_3;
  logic       cpu_rdy = 1'b1;
  logic       zero = 1'b0, error = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_tag;
  logic       res_zero, res_error, res_timeout, busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  cpu_cmd_sequencer #(.WIDTH(8), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
    .host_d1(host_d1), .host_d2(host_d2), .host_d3(host_d3),
    .cmd_in(cmd_in), .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .cpu_rdy(cpu_rdy), .zero(zero), .error(error),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_zero(res_zero), .res_error(res_error), .res_timeout(res_timeout),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] c, input logic [7:0] a);
    host_valid = 1'b1;
    host_cmd   = c;
    host_d1    = a;
    host_d2    = a + 8'd1;
    host_d3    = 8'h00;
    tick();
    host_valid = 1'b0;
  endtask

  // Push, then pop, ack and done on consecutive edges.
  task automatic run_cmd(input logic [6:0] c, input logic [7:0] a, input logic z, input logic e);
    push(c, a);
    tick();
    cpu_rdy = 1'b0;
    tick();
    zero    = z;
    error   = e;
    cpu_rdy = 1'b1;
    tick();
    zero    = 1'b0;
    error   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    #10;
    chk("rst_cmd_in", cmd_in, 0);
    chk("rst_din_1", din_1, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_host_ready", host_ready, 1);
    reset = 1'b1;

    // Single command, fast CPU
    push(7'h15, 8'h03);
    chk("t1_count_push", fifo_count, 1);
    chk("t1_idle_after_push", busy, 0);
    tick();
    chk("t1_cmd_issue", cmd_in, 7'h15);
    chk("t1_din1_issue", din_1, 8'h03);
    chk("t1_busy_issue", busy, 1);
    chk("t1_count_pop", fifo_count, 0);
    cpu_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_cmd_hold", cmd_in, 7'h15);
      chk("t1_din1_hold", din_1, 8'h03);
      chk("t1_no_result", res_valid, 0);
    end
    cpu_rdy = 1'b1;
    tick();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_tag", res_tag, 0);
    chk("t1_res_zero", res_zero, 0);
    chk("t1_res_error", res_error, 0);
    chk("t1_res_timeout", res_timeout, 0);
    chk("t1_cmd_nop", cmd_in, 0);
    chk("t1_din1_held", din_1, 8'h03);
    chk("t1_busy_done", busy, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t1_res_cleared", res_valid, 0);

    // Fill the FIFO with the CPU never ready
    reset = 1'b0;
    cpu_rdy = 1'b0;
    #3 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_valid = 1'b1;
      host_cmd   = 7'(i + 1);
      host_d1    = 8'(i + 8'h10);
      host_d2    = 8'h00;
      host_d3    = 8'h00;
      tick();
      if (i == 3) begin
        chk("t2_ready_full", host_ready, 0);
        chk("t2_count_full", fifo_count, 4);
      end
    end
    host_valid = 1'b0;
    chk("t2_count_refused", fifo_count, 4);
    chk("t2_no_issue_busy", busy, 0);
    chk("t2_no_issue_cmd", cmd_in, 0);

    // Ack timeout: CPU stays ready and never acknowledges
    cpu_rdy = 1'b1;
    tick();
    chk("t3_cmd_issue", cmd_in, 7'h01);
    chk("t3_din1_issue", din_1, 8'h10);
    chk("t3_count_pop", fifo_count, 3);
    chk("t3_ready_after_pop", host_ready, 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("t3_no_early_timeout", res_valid, 0);
      chk("t3_busy_wait", busy, 1);
    end
    chk("t3_cmd_hold", cmd_in, 7'h01);
    tick();
    chk("t3_res_valid", res_valid, 1);
    chk("t3_res_timeout", res_timeout, 1);
    chk("t3_res_zero", res_zero, 0);
    chk("t3_res_error", res_error, 0);
    chk("t3_res_tag", res_tag, 0);
    chk("t3_cmd_nop", cmd_in, 0);
    chk("t3_busy_idle", busy, 0);

    // Result backpressure: pending result blocks issue
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_blocked_busy", busy, 0);
      chk("t4_blocked_count", fifo_count, 3);
      chk("t4_pending", res_valid, 1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t4_issue_on_clear", cmd_in, 7'h02);
    chk("t4_din1_on_clear", din_1, 8'h11);
    chk("t4_res_cleared", res_valid, 0);
    chk("t4_count_pop", fifo_count, 2);
    cpu_rdy = 1'b0;
    tick();
    cpu_rdy = 1'b1;
    tick();
    chk("t4_res_valid", res_valid, 1);
    chk("t4_res_tag", res_tag, 1);
    chk("t4_res_timeout", res_timeout, 0);
    chk("t4_busy_idle", busy, 0);

    // Error capture and tag wrap over 257 commands
    reset = 1'b0;
    #1;
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_res_valid", res_valid, 0);
    chk("t5_rst_tag", res_tag, 0);
    reset = 1'b1;
    for (int i = 0; i < 257; i++) begin
      logic [7:0] etag;
      logic [7:0] ed1;
      etag = 8'(i);
      ed1  = 8'(i + 3);
      run_cmd(7'(i), ed1, (i == 2), (i == 2));
      chk("t5_res_valid", res_valid, 1);
      chk("t5_res_tag", res_tag, etag);
      chk("t5_din1_held", din_1, ed1);
      if (i == 2) begin
        chk("t5_err_capture", res_error, 1);
        chk("t5_zero_capture", res_zero, 1);
      end
      if (i == 3) begin
        chk("t5_err_clear", res_error, 0);
        chk("t5_zero_clear", res_zero, 0);
      end
      if (i == 256) chk("t5_cmd_nop", cmd_in, 0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end

    // Reset in WAIT_DONE with two commands queued
    push(7'h31, 8'hA0);
    push(7'h32, 8'hB0);
    push(7'h33, 8'hC0);
    cpu_rdy = 1'b0;
    tick();
    chk("t6_busy_before", busy, 1);
    chk("t6_count_before", fifo_count, 2);
    chk("t6_cmd_before", cmd_in, 7'h31);
    #2 reset = 1'b0;
    #1;
    chk("t6_busy_reset", busy, 0);
    chk("t6_count_reset", fifo_count, 0);
    chk("t6_cmd_reset", cmd_in, 0);
    chk("t6_res_valid_reset", res_valid, 0);
    chk("t6_ready_reset", host_ready, 1);
    cpu_rdy = 1'b1;
    reset = 1'b1;
    run_cmd(7'h22, 8'h55, 1'b0, 1'b0);
    chk("t6_post_res_valid", res_valid, 1);
    chk("t6_post_tag", res_tag, 0);
    chk("t6_post_timeout", res_timeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
